mailbox_ram: RTL and testbench
==============================

Name: mailbox_ram

Overview:
- Parametrised single-clock dual-port mailbox RAM; successor to the 41-bit x 32-entry SPI/Wishbone exchange RAM.
- Port A is the SPI side (producer). Port B is the Wishbone side (consumer).
- Each entry carries a valid flag: A writes mark an entry full, B consume-reads mark it empty.
- stop/ack handshakes provide back-pressure and completion. An occupancy counter and a not-empty flag feed the Wishbone interrupt logic.

Parameters:
- DATA_W, 41, entry data width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- OVERWRITE, 0, 1 = A may overwrite a valid entry; 0 = such a write is refused with a_stop.
- A_PRIORITY, 1, 1 = port A wins a same-address simultaneous write; 0 = port B wins.

Ports:
- clk  in  1  single clock for both ports.
- rst_n  in  1  asynchronous active-low reset.
- a_en  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A registered read data.
- a_ack  out  1  port A access completed, one cycle after request.
- a_stop  out  1  port A access refused, one cycle after request.
- b_en  in  1  port B access request.
- b_we  in  1  port B write / read.
- b_addr  in  ADDR_W  port B address.
- b_din  in  DATA_W  port B write data.
- b_consume  in  1  qualifies a B read as consuming; clears valid.
- b_dout  out  DATA_W  port B registered read data.
- b_ack  out  1  port B access completed.
- b_stop  out  1  port B consume-read of an empty entry.
- count  out  ADDR_W+1  number of valid entries.
- not_empty  out  1  count != 0, registered.

Behaviour:
- Reset (async assert, sync release):
  - valid[] all 0, count=0, not_empty=0.
  - a_ack, b_ack, a_stop, b_stop all 0.
  - a_dout and b_dout = 0.
  - RAM contents undefined; no reset of the array.
- Latency: every request sampled at cycle N produces exactly one of ack or stop at N+1, as a single-cycle pulse. Read data is valid on dout at N+1 and held until the next accepted read.
- A write:
  - Accepted if OVERWRITE=1 or valid[a_addr]=0.
  - On accept: mem[a_addr]<=a_din; valid set; a_ack.
  - Refused: no memory or valid change; a_stop.
- A read: always accepted; a_dout<=mem[a_addr]; valid unchanged; a_ack.
- B write: always accepted; mem[b_addr]<=b_din; valid unchanged; b_ack.
- B read, b_consume=0: always accepted; b_dout<=mem; b_ack.
- B read, b_consume=1:
  - valid=1: b_dout<=mem; valid cleared; b_ack.
  - valid=0: b_dout<=mem (stale); valid unchanged; b_stop.
- Read-during-write, same address, both ports: read-first; the reader gets the old data.
- Write/write collision, same address: the A_PRIORITY side's data is stored and both ports get ack. Valid follows the A-write rule.
- A write and B consume, same address, same cycle:
  - a_stop/accept is decided on the pre-cycle valid.
  - If the A write is accepted, the final valid=1 (set wins over clear).
  - Count nets the two events (+1-1=0).
- count: +1 per accepted A write that flips valid 0->1; -1 per accepted consume that flips 1->0.
  - Overwrite of an already-valid entry leaves count unchanged.
  - Saturation cannot occur: range is 0..2**ADDR_W.
- Full (count=depth) with OVERWRITE=0: every A write gives a_stop.
- Empty: every B consume gives b_stop.
- Reset mid-operation: pending ack/stop pulses are dropped and valid[] is cleared.

Decomposition:
- Shared package mailbox_pkg holds:
  - default DATA_W/ADDR_W constants;
  - the access-kind enum (IDLE, RD, WR, CONSUME);
  - the response enum (NONE, ACK, STOP).
- One sub-module, mailbox_ram_core: plain true-dual-port RAM array with read-first registered outputs and write-collision priority.
- The top level holds the valid[] vector, the accept/refuse logic, the ack/stop registers and count.

Test Plan:
- Reset, then A writes addr 3 = 0x1_2345_6789A. Required: a_ack at the next cycle, count=1, not_empty=1. Then B consume-reads addr 3: b_dout=0x1_2345_6789A, b_ack, count=0.
- OVERWRITE=0, A writes addr 7 twice (0xAA then 0xBB). Required: second write gives a_stop, count=1. A B read of addr 7 returns 0xAA.
- B consume-reads empty addr 9. Required: b_stop pulse for one cycle, count stays 0, b_ack=0.
- Same cycle: A writes addr 4 = 0x55 (previously valid=1, 0x11, OVERWRITE=1) and B consume-reads addr 4. Required: b_dout=0x11, a_ack, b_ack, valid[4]=1, count unchanged.
- Fill all 32 entries via A. Required: count=32. The 33rd write gets a_stop. Consume all 32 entries: count=0 and not_empty drops in the cycle after the last b_ack.
- Assert rst_n=0 mid-burst with count=5. Required: count=0 and ack/stop=0 immediately (asynchronous). After release, a consume-read of a previously written address gives b_stop.

Source files
------------

// File: rtl/mailbox_pkg.sv
// Shared types and default geometry for the SPI/Wishbone mailbox RAM.
package mailbox_pkg;
  localparam int unsigned DEF_DATA_W = 41;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic [1:0] {IDLE, RD, WR, CONSUME} access_e;
  typedef enum logic [1:0] {NONE, ACK, STOP} resp_e;
endpackage

// File: rtl/mailbox_ram_core.sv
// True dual-port RAM array: read-first registered outputs, configurable
// winner on a same-address write/write collision.
module mailbox_ram_core
  import mailbox_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned A_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_wr,
  input  logic              a_rd,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_wr,
  input  logic              b_rd,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic same_addr;
  logic a_store;
  logic b_store;

  always_comb begin
    same_addr = (a_addr == b_addr);
    a_store   = a_wr && !(b_wr && same_addr && (A_PRIORITY == 0));
    b_store   = b_wr && !(a_wr && same_addr && (A_PRIORITY != 0));
  end

  always_ff @(posedge clk) begin
    if (a_store) mem[a_addr] <= a_din;
    if (b_store) mem[b_addr] <= b_din;
  end

  // Reads sample mem before this edge's writes land, giving read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      if (a_rd) a_dout <= mem[a_addr];
      if (b_rd) b_dout <= mem[b_addr];
    end
  end
endmodule

// File: rtl/mailbox_ram.sv
// Mailbox RAM top: per-entry valid flags, accept/refuse decisions,
// ack/stop pulses and the occupancy count feeding the interrupt logic.
module mailbox_ram
  import mailbox_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned OVERWRITE  = 0,
  parameter int unsigned A_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_ack,
  output logic              a_stop,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  input  logic              b_consume,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_ack,
  output logic              b_stop,
  output logic [ADDR_W:0]   count,
  output logic              not_empty
);
  localparam int unsigned   DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = 1;

  access_e          a_kind, b_kind;
  resp_e            a_resp, b_resp;
  logic [DEPTH-1:0] valid, valid_next;
  logic             a_wr_ok, b_cons_ok, inc, dec;
  logic [ADDR_W:0]  count_next;

  always_comb begin
    a_kind = IDLE;
    if (a_en) a_kind = a_we ? WR : RD;
    b_kind = IDLE;
    if (b_en) b_kind = b_we ? WR : (b_consume ? CONSUME : RD);

    a_wr_ok   = (a_kind == WR) && ((OVERWRITE != 0) || !valid[a_addr]);
    b_cons_ok = (b_kind == CONSUME) && valid[b_addr];

    // A same-entry accepted write re-sets what the consume clears, so neither moves count.
    inc = a_wr_ok && !valid[a_addr];
    dec = b_cons_ok && !(a_wr_ok && (a_addr == b_addr));

    valid_next = valid;
    if (b_cons_ok) valid_next[b_addr] = 1'b0;
    if (a_wr_ok)   valid_next[a_addr] = 1'b1;

    count_next = count;
    if (inc && !dec)      count_next = count + ONE;
    else if (dec && !inc) count_next = count - ONE;

    case (a_kind)
      IDLE:    a_resp = NONE;
      WR:      a_resp = a_wr_ok ? ACK : STOP;
      default: a_resp = ACK;
    endcase
    case (b_kind)
      IDLE:    b_resp = NONE;
      CONSUME: b_resp = b_cons_ok ? ACK : STOP;
      default: b_resp = ACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      count     <= '0;
      not_empty <= 1'b0;
      a_ack     <= 1'b0;
      a_stop    <= 1'b0;
      b_ack     <= 1'b0;
      b_stop    <= 1'b0;
    end else begin
      valid     <= valid_next;
      count     <= count_next;
      // Registered from the current count, so it trails count by one cycle.
      not_empty <= (count != '0);
      a_ack     <= (a_resp == ACK);
      a_stop    <= (a_resp == STOP);
      b_ack     <= (b_resp == ACK);
      b_stop    <= (b_resp == STOP);
    end
  end

  mailbox_ram_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .A_PRIORITY(A_PRIORITY)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .a_wr  (a_wr_ok),
    .a_rd  (a_kind == RD),
    .a_addr(a_addr),
    .a_din (a_din),
    .a_dout(a_dout),
    .b_wr  (b_kind == WR),
    .b_rd  ((b_kind == RD) || (b_kind == CONSUME)),
    .b_addr(b_addr),
    .b_din (b_din),
    .b_dout(b_dout)
  );
endmodule

// File: tb/tb_mailbox_ram.sv
// Scoreboard bench for mailbox_ram: dut0 refuses overwrites (A wins collisions),
// dut1 allows overwrites (B wins collisions); both share the same stimulus.
module tb_mailbox_ram;
  import mailbox_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0, b_consume = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [40:0] a_din = '0, b_din = '0;

  logic [40:0] a_dout, b_dout, a_dout1, b_dout1;
  logic        a_ack, a_stop, b_ack, b_stop, not_empty;
  logic        a_ack1, a_stop1, b_ack1, b_stop1, not_empty1;
  logic [5:0]  count, count1;

  always #5 clk = ~clk;

  mailbox_ram #(.DATA_W(41), .ADDR_W(5), .OVERWRITE(0), .A_PRIORITY(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_ack(a_ack), .a_stop(a_stop),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_consume(b_consume),
    .b_dout(b_dout), .b_ack(b_ack), .b_stop(b_stop),
    .count(count), .not_empty(not_empty)
  );

  mailbox_ram #(.DATA_W(41), .ADDR_W(5), .OVERWRITE(1), .A_PRIORITY(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_ack(a_ack1), .a_stop(a_stop1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_consume(b_consume),
    .b_dout(b_dout1), .b_ack(b_ack1), .b_stop(b_stop1),
    .count(count1), .not_empty(not_empty1)
  );

  typedef struct {
    resp_e       resp;
    bit          chk_d;
    logic [40:0] d;
    int          cnt;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void cmp(string p, exp_t e, logic [1:0] act, logic [40:0] dout);
    check({p, "_resp"}, 64'(act), 64'(e.resp));
    check({p, "_latency"}, 64'(cyc), 64'(e.due));
    if (e.chk_d) check({p, "_dout"}, 64'(dout), 64'(e.d));
    if (e.cnt >= 0) check({p, "_count"}, 64'(count), 64'(e.cnt));
  endfunction

  // Monitors: one per port of dut0, popping an expectation on every response.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (a_ack || a_stop) begin
        if (qa.size() == 0) check("a_spurious", 64'({a_stop, a_ack}), 64'(NONE));
        else begin
          ea = qa.pop_front();
          cmp("a", ea, {a_stop, a_ack}, a_dout);
        end
      end
      if (qa.size() > 0 && qa[0].due < cyc) begin
        ea = qa.pop_front();
        check("a_missing", 64'(NONE), 64'(ea.resp));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (b_ack || b_stop) begin
        if (qb.size() == 0) check("b_spurious", 64'({b_stop, b_ack}), 64'(NONE));
        else begin
          eb = qb.pop_front();
          cmp("b", eb, {b_stop, b_ack}, b_dout);
        end
      end
      if (qb.size() > 0 && qb[0].due < cyc) begin
        eb = qb.pop_front();
        check("b_missing", 64'(NONE), 64'(eb.resp));
      end
    end
  end

  task automatic set_a(input logic we, input logic [4:0] addr, input logic [40:0] din,
                       input resp_e r, input bit cd, input logic [40:0] d, input int cnt);
    exp_t e;
    a_en = 1'b1; a_we = we; a_addr = addr; a_din = din;
    e.resp = r; e.chk_d = cd; e.d = d; e.cnt = cnt; e.due = cyc + 1;
    qa.push_back(e);
  endtask

  task automatic set_b(input logic we, input logic cons, input logic [4:0] addr,
                       input logic [40:0] din, input resp_e r, input bit cd,
                       input logic [40:0] d, input int cnt);
    exp_t e;
    b_en = 1'b1; b_we = we; b_consume = cons; b_addr = addr; b_din = din;
    e.resp = r; e.chk_d = cd; e.d = d; e.cnt = cnt; e.due = cyc + 1;
    qb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0; b_consume = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_count", 64'(count), 0);
    check("rst_not_empty", 64'(not_empty), 0);
    check("rst_acks", 64'({a_ack, a_stop, b_ack, b_stop}), 0);
    check("rst_douts", 64'(a_dout | b_dout), 0);

    // Basic produce / consume
    set_a(1, 5'd3, 41'h1_2345_6789A, ACK, 0, '0, 1); tick();
    tick();
    check("not_empty_after_write", 64'(not_empty), 1);
    set_b(0, 1, 5'd3, '0, ACK, 1, 41'h1_2345_6789A, 0); tick();

    // Refused overwrite
    set_a(1, 5'd7, 41'hAA, ACK, 0, '0, 1); tick();
    set_a(1, 5'd7, 41'hBB, STOP, 0, '0, 1); tick();
    set_b(0, 0, 5'd7, '0, ACK, 1, 41'hAA, 1); tick();
    set_b(0, 1, 5'd7, '0, ACK, 1, 41'hAA, 0); tick();

    // Consume of an empty entry
    set_b(0, 1, 5'd9, '0, STOP, 0, '0, 0); tick();
    tick();

    // Fill, refuse when full, drain
    for (int i = 0; i < 32; i++) begin
      set_a(1, 5'(i), 41'(256 + i), ACK, 0, '0, i + 1); tick();
    end
    set_a(1, 5'd5, 41'h999, STOP, 0, '0, 32); tick();
    for (int i = 0; i < 32; i++) begin
      set_b(0, 1, 5'(i), '0, ACK, 1, 41'(256 + i), 31 - i); tick();
    end
    check("not_empty_at_last_ack", 64'(not_empty), 1);
    tick();
    check("not_empty_after_drain", 64'(not_empty), 0);

    // Asynchronous reset with count=5 and an ack pulse live
    for (int i = 0; i < 4; i++) begin
      set_a(1, 5'(20 + i), 41'(i), ACK, 0, '0, i + 1); tick();
    end
    set_a(1, 5'd24, 41'h4, ACK, 0, '0, 5);
    @(posedge clk);
    #3;
    a_en = 1'b0; a_we = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 0);
    check("async_rst_acks", 64'({a_ack, a_stop, b_ack, b_stop}), 0);
    check("async_rst_not_empty", 64'(not_empty), 0);
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qb.delete();
    set_b(0, 1, 5'd20, '0, STOP, 0, '0, 0); tick();
    check("d1_rst_count", 64'(count1), 0);

    // Same-cycle write + consume of a valid entry
    set_a(1, 5'd4, 41'h11, ACK, 0, '0, 1); tick();
    check("d1_prep", 64'({a_ack1, count1}), 64'({1'b1, 6'd1}));
    set_a(1, 5'd4, 41'h55, STOP, 0, '0, 0);
    set_b(0, 1, 5'd4, '0, ACK, 1, 41'h11, 0); tick();
    check("d1_wc_acks", 64'({a_ack1, a_stop1, b_ack1, b_stop1}), 64'(4'b1010));
    check("d1_wc_dout", 64'(b_dout1), 64'h11);
    check("d1_wc_count", 64'(count1), 1);
    set_b(0, 1, 5'd4, '0, STOP, 1, 41'h11, 0); tick();
    check("d1_valid_kept", 64'({b_ack1, b_stop1}), 64'(2'b10));
    check("d1_new_data", 64'(b_dout1), 64'h55);
    check("d1_count_after", 64'(count1), 0);

    // Write/write collision and read-during-write
    set_a(1, 5'd10, 41'hA0, ACK, 0, '0, 1);
    set_b(1, 0, 5'd10, 41'hB0, ACK, 0, '0, 1); tick();
    check("d1_ww_acks", 64'({a_ack1, b_ack1, count1}), 64'({2'b11, 6'd1}));
    set_b(0, 1, 5'd10, '0, ACK, 1, 41'hA0, 0); tick();
    check("d1_ww_bprio", 64'(b_dout1), 64'hB0);
    set_a(0, 5'd10, '0, ACK, 1, 41'hA0, 0);
    set_b(1, 0, 5'd10, 41'hCC, ACK, 0, '0, 0); tick();
    set_b(0, 0, 5'd10, '0, ACK, 1, 41'hCC, 0); tick();

    repeat (3) tick();
    check("scoreboard_drained", 64'(qa.size() + qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
